nibble_serial_add_ctrl: RTL and testbench

//  Sequencer that runs one full_adder_4bit instance over WIDTH-bit operands, one nibble per clock,
//  LSB nibble first, with the carry held in a register between nibbles. Gives wide add/subtract
//  on the multiplier datapath (partial-product accumulation) for the area of one 4-bit adder.

---
 rtl/nibble_serial_add_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// full_adder_4bit
//   Purpose : purely combinational 4-bit ripple adder with carry in/out. This is
//             the single arithmetic cell that the serial controller reuses once
//             per nibble.
//   Ports   : a_i, b_i  [3:0]  nibble operands
//             cin_i            carry into bit 0
//             sum_o     [3:0]  nibble sum
//             cout_o           carry out of bit 3
// -----------------------------------------------------------------------------
module full_adder_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [4:0] total;

   assign total  = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
   assign sum_o  = total[3:0];
   assign cout_o = total[4];

endmodule

// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//   Purpose : bit-serial (nibble-serial) wide add/subtract. One full_adder_4bit
//             is stepped across WIDTH-bit operands, least significant nibble
//             first, with the carry held in a register between nibbles. One
//             operation is in flight at a time; valid/ready on both sides.
//   Params  : WIDTH        operand/result width, multiple of 4 and >= 4
//   Ports   : clk          rising-edge clock
//             rst_n        asynchronous active-low reset
//             start_valid  request carries valid operands
//             start_ready  controller can accept (IDLE only)
//             operand_a    addend / minuend
//             operand_b    addend / subtrahend
//             carry_in     add: carry in, subtract: borrow in
//             sub          0 = A+B+cin, 1 = A-B-borrow
//             result       sum / difference
//             carry_out    add: carry, subtract: 1 = no borrow
//             overflow     two's-complement signed overflow
//             result_valid result/carry_out/overflow valid
//             result_ready consumer takes the result
//             busy         operation in RUN or DONE
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             carry_in,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / 4;
   // Keep the counter at least one bit wide so WIDTH=4 still elaborates.
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   generate
      if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
         $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_out_q;
   logic             overflow_q;
   logic             result_valid_q;
   logic             busy_q;
   logic             start_ready_q;

   logic [3:0]       sum4;
   logic             cout4;
   logic [WIDTH-1:0] result_shift;
   logic             last_nibble;
   logic             ovf_nibble;

   // Single shared adder; subtraction arrives here already as A + ~B + ~borrow.
   full_adder_4bit u_fa (
      .a_i   (a_sh_q[3:0]),
      .b_i   (b_sh_q[3:0]),
      .cin_i (carry_q),
      .sum_o (sum4),
      .cout_o(cout4)
   );

   // New nibble enters at the top; after NIBBLES shifts the first nibble has
   // reached bit 0, so the result register ends up in natural bit order.
   generate
      if (NIBBLES == 1) begin : g_res_single
         assign result_shift = sum4;
      end else begin : g_res_multi
         assign result_shift = {sum4, result_q[WIDTH-1:4]};
      end
   endgenerate

   assign last_nibble = (cnt_q == LAST_CNT);

   // Signed overflow is decided by the top nibble alone: same-sign inputs
   // (after the optional inversion of B) producing a different-sign sum.
   assign ovf_nibble = (a_sh_q[3] == b_sh_q[3]) && (sum4[3] != a_sh_q[3]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         carry_q        <= 1'b0;
         a_sh_q         <= '0;
         b_sh_q         <= '0;
         result_q       <= '0;
         carry_out_q    <= 1'b0;
         overflow_q     <= 1'b0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         start_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_valid) begin
                  a_sh_q        <= operand_a;
                  b_sh_q        <= sub ? ~operand_b : operand_b;
                  // Carry is always reloaded so nothing leaks from the previous op.
                  carry_q       <= sub ? ~carry_in : carry_in;
                  cnt_q         <= '0;
                  busy_q        <= 1'b1;
                  start_ready_q <= 1'b0;
                  state_q       <= ST_RUN;
               end
            end

            ST_RUN: begin
               result_q <= result_shift;
               a_sh_q   <= a_sh_q >> 4;
               b_sh_q   <= b_sh_q >> 4;
               carry_q  <= cout4;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_nibble) begin
                  overflow_q     <= ovf_nibble;
                  carry_out_q    <= cout4;
                  result_valid_q <= 1'b1;
                  state_q        <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (result_ready) begin
                  result_valid_q <= 1'b0;
                  busy_q         <= 1'b0;
                  start_ready_q  <= 1'b1;
                  state_q        <= ST_IDLE;
               end
            end

            default: begin
               state_q        <= ST_IDLE;
               result_valid_q <= 1'b0;
               busy_q         <= 1'b0;
               start_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign start_ready  = start_ready_q;
   assign result       = result_q;
   assign carry_out    = carry_out_q;
   assign overflow     = overflow_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//   Directed bench for nibble_serial_add_ctrl: one WIDTH=16 instance for the
//   main vectors and one WIDTH=4 instance for the single-nibble case.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // WIDTH=16 instance
   logic        start_valid, start_ready;
   logic [15:0] operand_a, operand_b;
   logic        carry_in, sub;
   logic [15:0] result;
   logic        carry_out, overflow, result_valid, result_ready, busy;

   // WIDTH=4 instance
   logic       s4_start_valid, s4_start_ready;
   logic [3:0] s4_operand_a, s4_operand_b;
   logic       s4_carry_in, s4_sub;
   logic [3:0] s4_result;
   logic       s4_carry_out, s4_overflow, s4_result_valid, s4_result_ready, s4_busy;

   int checks = 0;
   int errors = 0;

   nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .carry_in    (carry_in),
      .sub         (sub),
      .result      (result),
      .carry_out   (carry_out),
      .overflow    (overflow),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .busy        (busy)
   );

   nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (s4_start_valid),
      .start_ready (s4_start_ready),
      .operand_a   (s4_operand_a),
      .operand_b   (s4_operand_b),
      .carry_in    (s4_carry_in),
      .sub         (s4_sub),
      .result      (s4_result),
      .carry_out   (s4_carry_out),
      .overflow    (s4_overflow),
      .result_valid(s4_result_valid),
      .result_ready(s4_result_ready),
      .busy        (s4_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for result_valid on the 16-bit instance; returns the
   // number of rising edges seen since the accepting edge.
   task automatic wait_valid16(output int lat);
      lat = 0;
      while (!result_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic s, input logic [15:0] exp_res,
                        input logic exp_c, input logic exp_ovf);
      int lat;
      @(negedge clk);
      check({tag, " start_ready"}, 32'(start_ready), 32'd1);
      operand_a   = a;
      operand_b   = b;
      carry_in    = cin;
      sub         = s;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      operand_a   = 16'hDEAD;
      operand_b   = 16'hBEEF;
      wait_valid16(lat);
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " result"}, 32'(result), 32'(exp_res));
      check({tag, " carry_out"}, 32'(carry_out), 32'(exp_c));
      check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
      $display("op %s: a=0x%h b=0x%h cin=%0d sub=%0d -> res=0x%h c=%0d ovf=%0d lat=%0d",
               tag, a, b, cin, s, result, carry_out, overflow, lat);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check({tag, " valid dropped"}, 32'(result_valid), 32'd0);
      check({tag, " idle again"}, 32'(start_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int seen_valid;

      rst_n          = 1'b0;
      start_valid    = 1'b0;
      operand_a      = '0;
      operand_b      = '0;
      carry_in       = 1'b0;
      sub            = 1'b0;
      result_ready   = 1'b0;
      s4_start_valid = 1'b0;
      s4_operand_a   = '0;
      s4_operand_b   = '0;
      s4_carry_in    = 1'b0;
      s4_sub         = 1'b0;
      s4_result_ready = 1'b0;

      // Reset state
      #12;
      check("rst result", 32'(result), 32'd0);
      check("rst valid", 32'(result_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst carry_out", 32'(carry_out), 32'd0);
      check("rst overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst start_ready", 32'(start_ready), 32'd1);
      $display("reset: start_ready=%0d busy=%0d valid=%0d", start_ready, busy, result_valid);

      // Add vectors
      run16("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
      run16("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run16("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run16("add_cin",       16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
      // Subtract vectors
      run16("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run16("sub_8000_1",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run16("sub_borrow",    16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

      // Stall in DONE with a pending request, then back-to-back accept
      @(negedge clk);
      operand_a   = 16'h1111;
      operand_b   = 16'h2222;
      carry_in    = 1'b0;
      sub         = 1'b0;
      start_valid = 1'b1;
      @(negedge clk);
      operand_a   = 16'h0100;
      operand_b   = 16'h0023;
      sub         = 1'b1;
      wait_valid16(lat);
      check("stall latency", 32'(lat), 32'd4);
      for (int i = 0; i < 10; i++) begin
         check("stall result", 32'(result), 32'h3333);
         check("stall valid", 32'(result_valid), 32'd1);
         check("stall start_ready", 32'(start_ready), 32'd0);
         check("stall busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      $display("stall: held 10 clks res=0x%h valid=%0d", result, result_valid);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("b2b idle", 32'(start_ready), 32'd1);
      check("b2b valid dropped", 32'(result_valid), 32'd0);
      @(negedge clk);
      start_valid = 1'b0;
      check("b2b accepted", 32'(busy), 32'd1);
      wait_valid16(lat);
      check("b2b latency", 32'(lat), 32'd4);
      check("b2b result", 32'(result), 32'h00DD);
      check("b2b carry_out", 32'(carry_out), 32'd1);
      check("b2b overflow", 32'(overflow), 32'd0);
      $display("b2b: res=0x%h c=%0d ovf=%0d lat=%0d", result, carry_out, overflow, lat);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;

      // Reset during the second RUN cycle
      @(negedge clk);
      operand_a   = 16'hFFFF;
      operand_b   = 16'hFFFF;
      carry_in    = 1'b1;
      sub         = 1'b0;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrun rst valid", 32'(result_valid), 32'd0);
      check("midrun rst busy", 32'(busy), 32'd0);
      check("midrun rst result", 32'(result), 32'd0);
      check("midrun rst carry_out", 32'(carry_out), 32'd0);
      check("midrun rst overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (result_valid) seen_valid++;
      end
      check("midrun no valid pulse", 32'(seen_valid), 32'd0);
      check("midrun start_ready", 32'(start_ready), 32'd1);
      $display("midrun reset: valid pulses after release=%0d", seen_valid);
      run16("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

      // WIDTH=4 single-nibble case
      @(negedge clk);
      check("w4 start_ready", 32'(s4_start_ready), 32'd1);
      s4_operand_a   = 4'h9;
      s4_operand_b   = 4'h9;
      s4_carry_in    = 1'b1;
      s4_sub         = 1'b0;
      s4_start_valid = 1'b1;
      @(negedge clk);
      s4_start_valid = 1'b0;
      lat = 0;
      while (!s4_result_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("w4 latency", 32'(lat), 32'd1);
      check("w4 result", 32'(s4_result), 32'h3);
      check("w4 carry_out", 32'(s4_carry_out), 32'd1);
      check("w4 overflow", 32'(s4_overflow), 32'd1);
      $display("w4: res=0x%h c=%0d ovf=%0d lat=%0d", s4_result, s4_carry_out, s4_overflow, lat);
      s4_result_ready = 1'b1;
      @(negedge clk);
      s4_result_ready = 1'b0;
      check("w4 valid dropped", 32'(s4_result_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
